// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle between the two requesters, the clear control and the register file write port.
// Pure wiring, no latency; the ready lines are the only backpressure toward the requesters.
// Requesters hold valid/addr/data stable until ready; the write port side has no backpressure.
//
// Signals:
//   a_valid/a_addr/a_data/a_ready : ALU writeback request and its grant
//   b_valid/b_addr/b_data/b_ready : load writeback request and its grant
//   clr_req/clr_done/busy         : clear-all request, last-write pulse, sweep in progress
//   reg_write/wr_addr/wr_data     : register file write port
// Modports: master = requester/control side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              clr_req;
  logic              clr_done;
  logic              busy;

  logic              reg_write;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output clr_req,
    input  a_ready, b_ready, clr_done, busy,
    input  reg_write, wr_addr, wr_data
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  clr_req,
    output a_ready, b_ready, clr_done, busy,
    output reg_write, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A) and load (B) writebacks, plus a zero-all sweep.
// Latency: handshake at edge t drives the write port after edge t; the sweep writes one register per cycle.
// Backpressure: a_ready/b_ready are combinational grants; both stay low during the sweep and while in reset.
//
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   wb     : regfile_wb_arbiter_if.slave (requests, grants, clear control, registered write port)
module regfile_wb_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  regfile_wb_arbiter_if.slave  wb
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            state_q;
  logic              rr_q;        // 0: A wins a tie, 1: B wins a tie
  logic [ADDR_W-1:0] clr_idx_q;
  logic              reg_write_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              clr_done_q;

  logic arb_en;
  logic grant_a;
  logic grant_b;
  logic clr_last;

  // Grants are only offered in IDLE with no clear pending; a clear request
  // in the same cycle takes priority over both requesters.
  assign arb_en  = (state_q == S_IDLE) && !wb.clr_req;
  assign grant_a = arb_en && wb.a_valid && (!wb.b_valid || !rr_q);
  assign grant_b = arb_en && wb.b_valid && (!wb.a_valid ||  rr_q);

  // Grants are masked while reset is asserted so a requester can never see
  // a handshake that the (held-in-reset) datapath would not record.
  assign wb.a_ready = grant_a && rst_ni;
  assign wb.b_ready = grant_b && rst_ni;

  assign clr_last = (clr_idx_q == {ADDR_W{1'b1}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      clr_idx_q   <= '0;
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          clr_done_q <= 1'b0;
          if (wb.clr_req) begin
            state_q     <= S_CLEAR;
            clr_idx_q   <= '0;
            reg_write_q <= 1'b0;
          end else if (grant_a) begin
            reg_write_q <= 1'b1;
            wr_addr_q   <= wb.a_addr;
            wr_data_q   <= wb.a_data;
            rr_q        <= 1'b1;
          end else if (grant_b) begin
            reg_write_q <= 1'b1;
            wr_addr_q   <= wb.b_addr;
            wr_data_q   <= wb.b_data;
            rr_q        <= 1'b0;
          end else begin
            // Address/data hold their last values; only the enable drops.
            reg_write_q <= 1'b0;
          end
        end

        S_CLEAR: begin
          reg_write_q <= 1'b1;
          wr_addr_q   <= clr_idx_q;
          wr_data_q   <= '0;
          clr_idx_q   <= clr_idx_q + ADDR_W'(1);  // wraps to 0 after the last register
          if (clr_last) begin
            clr_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            clr_done_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          reg_write_q <= 1'b0;
          clr_done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wb.reg_write = reg_write_q;
  assign wb.wr_addr   = wr_addr_q;
  assign wb.wr_data   = wr_data_q;
  assign wb.clr_done  = clr_done_q;
  assign wb.busy      = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single grant, contention, fairness, clear sweep, reset mid-sweep.
// Inputs change away from the rising edge; outputs are sampled 1 time unit after it (or after input changes).
// Expected values are hand-derived constants per scenario.
module tb_regfile_wb_arbiter;

  logic clk_i;
  logic rst_ni;
  int   vecs;
  int   errs;

  regfile_wb_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  regfile_wb_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wb     (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    idle_inputs();
    #1 rst_ni = 1'b0;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #2;
    vecs++; if (bus.a_ready !== 1'b0) begin errs++; $display("FAIL rst_a_ready: got %b want 0", bus.a_ready); end
    vecs++; if (bus.b_ready !== 1'b0) begin errs++; $display("FAIL rst_b_ready: got %b want 0", bus.b_ready); end
    vecs++; if (bus.reg_write !== 1'b0) begin errs++; $display("FAIL rst_reg_write: got %b want 0", bus.reg_write); end
    vecs++; if (bus.wr_addr !== 3'd0) begin errs++; $display("FAIL rst_wr_addr: got %0d want 0", bus.wr_addr); end
    vecs++; if (bus.wr_data !== 8'h00) begin errs++; $display("FAIL rst_wr_data: got %h want 00", bus.wr_data); end
    vecs++; if (bus.clr_done !== 1'b0) begin errs++; $display("FAIL rst_clr_done: got %b want 0", bus.clr_done); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    repeat (2) @(posedge clk_i);
    #1;
    vecs++; if (bus.reg_write !== 1'b0) begin errs++; $display("FAIL rst_held_reg_write: got %b want 0", bus.reg_write); end
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      vecs++; if (bus.reg_write !== 1'b0) begin errs++; $display("FAIL idle_reg_write[%0d]: got %b want 0", i, bus.reg_write); end
      vecs++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
        errs++; $display("FAIL idle_ready[%0d]: got a=%b b=%b want a=0 b=0", i, bus.a_ready, bus.b_ready);
      end
    end
  endtask

  task automatic test_single();
    @(negedge clk_i);
    bus.a_valid = 1'b1; bus.a_addr = 3'd3; bus.a_data = 8'h5A;
    #1;
    vecs++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errs++; $display("FAIL single_ready: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready);
    end
    @(posedge clk_i);
    #1;
    bus.a_valid = 1'b0;
    vecs++; if (bus.reg_write !== 1'b1 || bus.wr_addr !== 3'd3 || bus.wr_data !== 8'h5A) begin
      errs++; $display("FAIL single_write: got we=%b addr=%0d data=%h want we=1 addr=3 data=5a", bus.reg_write, bus.wr_addr, bus.wr_data);
    end
    @(posedge clk_i);
    #1;
    vecs++; if (bus.reg_write !== 1'b0 || bus.wr_addr !== 3'd3 || bus.wr_data !== 8'h5A) begin
      errs++; $display("FAIL single_hold: got we=%b addr=%0d data=%h want we=0 addr=3 data=5a", bus.reg_write, bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge clk_i);
    bus.a_valid = 1'b1; bus.a_addr = 3'd1; bus.a_data = 8'h11;
    bus.b_valid = 1'b1; bus.b_addr = 3'd2; bus.b_data = 8'h22;
    #1;
    vecs++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errs++; $display("FAIL cont_first: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready);
    end
    @(posedge clk_i);
    #1;
    bus.a_valid = 1'b0;
    #1;
    vecs++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
      errs++; $display("FAIL cont_second: got a=%b b=%b want a=0 b=1", bus.a_ready, bus.b_ready);
    end
    vecs++; if (bus.reg_write !== 1'b1 || bus.wr_addr !== 3'd1 || bus.wr_data !== 8'h11) begin
      errs++; $display("FAIL cont_write_a: got we=%b addr=%0d data=%h want we=1 addr=1 data=11", bus.reg_write, bus.wr_addr, bus.wr_data);
    end
    @(posedge clk_i);
    #1;
    bus.b_valid = 1'b0;
    vecs++; if (bus.reg_write !== 1'b1 || bus.wr_addr !== 3'd2 || bus.wr_data !== 8'h22) begin
      errs++; $display("FAIL cont_write_b: got we=%b addr=%0d data=%h want we=1 addr=2 data=22", bus.reg_write, bus.wr_addr, bus.wr_data);
    end
    @(posedge clk_i);
    #1;
    vecs++; if (bus.reg_write !== 1'b0) begin errs++; $display("FAIL cont_done: got we=%b want 0", bus.reg_write); end
  endtask

  // Last grant was B, so the alternation must start with A.
  task automatic test_fairness();
    logic exp_a;
    bus.a_valid = 1'b1; bus.a_addr = 3'd5; bus.a_data = 8'hA5;
    bus.b_valid = 1'b1; bus.b_addr = 3'd6; bus.b_data = 8'hB6;
    for (int i = 0; i < 6; i++) begin
      exp_a = ((i % 2) == 0);
      @(negedge clk_i);
      vecs++; if (bus.a_ready !== exp_a || bus.b_ready !== !exp_a) begin
        errs++; $display("FAIL fair_grant[%0d]: got a=%b b=%b want a=%b b=%b", i, bus.a_ready, bus.b_ready, exp_a, !exp_a);
      end
      @(posedge clk_i);
      #1;
      vecs++; if (bus.reg_write !== 1'b1 || bus.wr_addr !== (exp_a ? 3'd5 : 3'd6) || bus.wr_data !== (exp_a ? 8'hA5 : 8'hB6)) begin
        errs++; $display("FAIL fair_write[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d", i, bus.reg_write, bus.wr_addr, bus.wr_data, exp_a ? 5 : 6);
      end
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  // An uncontended grant must still move the round-robin pointer.
  task automatic test_rr_after_single();
    @(negedge clk_i);
    bus.a_valid = 1'b1; bus.a_addr = 3'd4; bus.a_data = 8'h44;
    @(posedge clk_i);
    #1;
    bus.a_valid = 1'b0;
    @(negedge clk_i);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1; bus.b_addr = 3'd5; bus.b_data = 8'h55;
    #1;
    vecs++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
      errs++; $display("FAIL rr_after_a: got a=%b b=%b want a=0 b=1", bus.a_ready, bus.b_ready);
    end
    @(posedge clk_i);
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    vecs++; if (bus.wr_addr !== 3'd5 || bus.wr_data !== 8'h55) begin
      errs++; $display("FAIL rr_after_a_write: got addr=%0d data=%h want addr=5 data=55", bus.wr_addr, bus.wr_data);
    end
    @(negedge clk_i);
    bus.b_valid = 1'b1; bus.b_addr = 3'd6; bus.b_data = 8'h66;
    @(posedge clk_i);
    #1;
    bus.b_valid = 1'b0;
    @(negedge clk_i);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #1;
    vecs++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      errs++; $display("FAIL rr_after_b: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready);
    end
    @(posedge clk_i);
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic test_clear();
    logic [2:0] exp_addr;
    @(negedge clk_i);
    bus.clr_req = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 3'd7; bus.a_data = 8'h77;
    #1;
    vecs++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      errs++; $display("FAIL clr_blocks_grant: got a=%b b=%b want a=0 b=0", bus.a_ready, bus.b_ready);
    end
    @(posedge clk_i);
    #1;
    bus.clr_req = 1'b0;
    vecs++; if (bus.busy !== 1'b1 || bus.reg_write !== 1'b0) begin
      errs++; $display("FAIL clr_enter: got busy=%b we=%b want busy=1 we=0", bus.busy, bus.reg_write);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 3) bus.clr_req = 1'b1;   // must be ignored mid-sweep
      if (k == 5) bus.clr_req = 1'b0;
      exp_addr = 3'(k);
      @(posedge clk_i);
      #1;
      vecs++; if (bus.reg_write !== 1'b1 || bus.wr_addr !== exp_addr || bus.wr_data !== 8'h00) begin
        errs++; $display("FAIL clr_write[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=00", k, bus.reg_write, bus.wr_addr, bus.wr_data, exp_addr);
      end
      vecs++; if (bus.clr_done !== (k == 7) || bus.busy !== (k != 7)) begin
        errs++; $display("FAIL clr_flags[%0d]: got done=%b busy=%b want done=%b busy=%b", k, bus.clr_done, bus.busy, k == 7, k != 7);
      end
      vecs++; if (bus.a_ready !== (k == 7)) begin
        errs++; $display("FAIL clr_a_ready[%0d]: got %b want %b", k, bus.a_ready, k == 7);
      end
    end
    @(posedge clk_i);
    #1;
    bus.a_valid = 1'b0;
    vecs++; if (bus.reg_write !== 1'b1 || bus.wr_addr !== 3'd7 || bus.wr_data !== 8'h77 || bus.clr_done !== 1'b0) begin
      errs++; $display("FAIL clr_resume: got we=%b addr=%0d data=%h done=%b want we=1 addr=7 data=77 done=0", bus.reg_write, bus.wr_addr, bus.wr_data, bus.clr_done);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [2:0] exp_addr;
    @(negedge clk_i);
    bus.clr_req = 1'b1;
    @(posedge clk_i);
    #1;
    bus.clr_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_addr = 3'(k);
      @(posedge clk_i);
      #1;
      vecs++; if (bus.wr_addr !== exp_addr) begin
        errs++; $display("FAIL mid_write[%0d]: got addr=%0d want %0d", k, bus.wr_addr, exp_addr);
      end
    end
    rst_ni = 1'b0;
    #1;
    vecs++; if (bus.reg_write !== 1'b0 || bus.wr_addr !== 3'd0 || bus.wr_data !== 8'h00 || bus.busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      errs++; $display("FAIL mid_abort: got we=%b addr=%0d data=%h busy=%b done=%b want all 0", bus.reg_write, bus.wr_addr, bus.wr_data, bus.busy, bus.clr_done);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      vecs++; if (bus.clr_done !== 1'b0 || bus.busy !== 1'b0) begin
        errs++; $display("FAIL mid_held[%0d]: got done=%b busy=%b want 0 0", i, bus.clr_done, bus.busy);
      end
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    bus.clr_req = 1'b1;
    @(posedge clk_i);
    #1;
    bus.clr_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_addr = 3'(k);
      @(posedge clk_i);
      #1;
      vecs++; if (bus.reg_write !== 1'b1 || bus.wr_addr !== exp_addr || bus.clr_done !== (k == 7)) begin
        errs++; $display("FAIL restart[%0d]: got we=%b addr=%0d done=%b want we=1 addr=%0d done=%b", k, bus.reg_write, bus.wr_addr, bus.clr_done, exp_addr, k == 7);
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_rr_after_single();
    test_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
